// File: rtl/bus_initiator_if.sv
// otter_bus: single-clock primary/secondary memory bus. The secondary answers
// error combinationally from addr/size; rdata is valid a fixed latency after rd.
interface otter_bus #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic clk
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic [BUS_WIDTH-1:0]  wdata;
    logic                  rd;
    logic                  wr;
    logic [BUS_WIDTH-1:0]  rdata;
    logic                  error;

    modport primary   (input clk, output addr, size, wdata, rd, wr, input rdata, error);
    modport secondary (input clk, input addr, size, wdata, rd, wr, output rdata, error);
endinterface

// File: rtl/bus_initiator.sv
// Core-side load/store initiator for otter_bus: one outstanding access,
// store lane replication, load lane extraction with sign/zero extension.
module bus_initiator #(
    parameter int BUS_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic [BUS_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_error,
    otter_bus.primary             bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    state_t                state, state_nx;
    logic                  we_q, uns_q, err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0]  wdata_q, rdata_q, bus_wdata;
    logic [2:0]            cnt;
    logic                  fire, bad, last, bus_rd, bus_wr;

    function automatic logic [BUS_WIDTH-1:0] extract(input logic [BUS_WIDTH-1:0] d,
                                                     input logic [1:0] sz,
                                                     input logic [1:0] lane,
                                                     input logic uns);
        logic [BUS_WIDTH-1:0] sh;
        sh = d >> {lane, 3'b000};
        case (sz)
            2'b00:   return {{(BUS_WIDTH-8){~uns & sh[7]}}, sh[7:0]};
            2'b01:   return {{(BUS_WIDTH-16){~uns & sh[15]}}, sh[15:0]};
            default: return d;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign fire      = req_valid && req_ready;
    // reserved size is an error regardless of what the secondary says
    assign bad       = bus.error || (size_q == 2'b11);
    assign last      = (cnt == 3'd0);

    always_comb begin
        state_nx = state;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        case (state)
            IDLE:  if (fire) state_nx = ISSUE;
            ISSUE: begin
                state_nx = (we_q || bad) ? RESP : WAIT;
                if (rst_n && !bad) begin
                    bus_rd = !we_q;
                    bus_wr = we_q;
                end
            end
            WAIT:  if (last) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   bus_wdata = {(BUS_WIDTH/8){wdata_q[7:0]}};
            2'b01:   bus_wdata = {(BUS_WIDTH/16){wdata_q[15:0]}};
            default: bus_wdata = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (fire) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            case (state)
                ISSUE: begin
                    err_q   <= bad;
                    rdata_q <= '0;
                    cnt     <= CNT_INIT;
                end
                WAIT: begin
                    if (last) rdata_q <= extract(bus.rdata, size_q, addr_q[1:0], uns_q);
                    else      cnt     <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;

    assign bus.addr  = addr_q;
    assign bus.size  = size_q;
    assign bus.wdata = bus_wdata;
    assign bus.rd    = bus_rd;
    assign bus.wr    = bus_wr;
endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a byte-lane memory secondary on a
// READ_LATENCY=1 instance, plus a READ_LATENCY=3 instance for reset-in-WAIT.
module tb_bus_initiator;
    localparam int BW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          req_valid, req_we, req_unsigned, req_ready, rsp_valid, rsp_error;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_wdata, rsp_rdata;

    logic          req_valid3, req_ready3, rsp_valid3, rsp_error3;
    logic [AW-1:0] req_addr3;
    logic [BW-1:0] rsp_rdata3;

    otter_bus #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus1 (.clk(clk));
    otter_bus #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus3 (.clk(clk));

    bus_initiator #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .bus(bus1.primary));

    bus_initiator #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(1'b0), .req_size(2'b10), .req_unsigned(1'b0),
        .req_addr(req_addr3), .req_wdata(32'h0), .rsp_valid(rsp_valid3),
        .rsp_rdata(rsp_rdata3), .rsp_error(rsp_error3), .bus(bus3.primary));

    // secondary models: alignment errors only (reserved size deliberately not flagged)
    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [3:0]  rd_sh1 = '0;
    logic [3:0]  rd_sh3 = '0;

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            default: return 1'b0;
        endcase
    endfunction

    assign bus1.error = model_err(bus1.size, bus1.addr);
    assign bus1.rdata = rd_sh1[0] ? mem[bus1.addr[7:2]] : 32'hBAD0BAD0;
    assign bus3.error = 1'b0;
    assign bus3.rdata = rd_sh3[2] ? 32'h12345678 : 32'hBAD0BAD0;

    always @(posedge clk) begin
        logic [3:0] be;
        rd_sh1 <= {rd_sh1[2:0], bus1.rd};
        rd_sh3 <= {rd_sh3[2:0], bus3.rd};
        case (bus1.size)
            2'b00:   be = 4'b0001 << bus1.addr[1:0];
            2'b01:   be = 4'b0011 << bus1.addr[1:0];
            default: be = 4'b1111;
        endcase
        if (bus1.wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[bus1.addr[7:2]][8*b +: 8] <= bus1.wdata[8*b +: 8];
    end

    // negedge monitor
    int          cyc = 0, rd1_cnt = 0, wr1_cnt = 0, ovl = 0, rstbus = 0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] wr1_data = '0;
    int          hs_q[$], rsp_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus1.rd) rd1_cnt <= rd1_cnt + 1;
        if (bus1.wr) begin wr1_cnt <= wr1_cnt + 1; wr1_data <= bus1.wdata; end
        if ((bus1.rd && bus1.wr) || (bus1.rd && prev_rd) || (bus1.wr && prev_wr)) ovl <= ovl + 1;
        if (!rst_n && (bus1.rd || bus1.wr || bus3.rd || bus3.wr)) rstbus <= rstbus + 1;
        prev_rd <= bus1.rd;
        prev_wr <= bus1.wr;
        if (req_valid && req_ready) hs_q.push_back(cyc);
        if (rsp_valid) rsp_q.push_back(cyc);
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata, exp_rdata;
        logic        exp_err;
        int          exp_lat, exp_rd, exp_wr;
        logic [31:0] exp_bwd;
    } vec_t;

    task automatic run_vec(input vec_t v, input int i);
        int rd0, wr0, w, n;
        logic got;
        rd0 = rd1_cnt; wr0 = wr1_cnt; w = 0; n = 0; got = 1'b0;
        @(posedge clk); #1;
        req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFFFFF0; req_wdata = 32'h0; req_size = 2'b00;
        while (n < 12 && !got) begin
            @(negedge clk); n++;
            if (n == 1) begin
                chk($sformatf("v%0d_bus_addr", i), bus1.addr, v.addr);
                chk($sformatf("v%0d_bus_size", i), 32'(bus1.size), 32'(v.size));
            end
            if (rsp_valid) got = 1'b1;
        end
        chk($sformatf("v%0d_latency", i), got ? 32'(n) : 32'hFFFFFFFF, 32'(v.exp_lat));
        chk($sformatf("v%0d_rdata", i), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_error", i), 32'(rsp_error), 32'(v.exp_err));
        chk($sformatf("v%0d_addr_stable", i), bus1.addr, v.addr);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_one_cycle", i), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_rd_pulses", i), 32'(rd1_cnt - rd0), 32'(v.exp_rd));
        chk($sformatf("v%0d_wr_pulses", i), 32'(wr1_cnt - wr0), 32'(v.exp_wr));
        if (v.exp_wr != 0) chk($sformatf("v%0d_bus_wdata", i), wr1_data, v.exp_bwd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[19];
        int   n, cnt3;
        logic got;
        //          we    size  uns   addr      wdata         exp_rdata     err  lat rd wr bus_wdata
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 32'h00000000, 1'b0, 2, 0, 1, 32'hA5A5A5A5};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0, 3, 1, 0, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000A5, 1'b0, 3, 1, 0, 32'h0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h000000BE, 1'b0, 3, 1, 0, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 3, 1, 0, 32'h0};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h80017FFF, 32'h00000000, 1'b0, 2, 0, 1, 32'h80017FFF};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 1, 0, 32'h0};
        vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h20, 32'h0,        32'h00007FFF, 1'b0, 3, 1, 0, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0,        32'h00007FFF, 1'b0, 3, 1, 0, 32'h0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        32'h00000000, 1'b1, 2, 0, 0, 32'h0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1, 2, 0, 0, 32'h0};
        vecs[13] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h11111111, 32'h00000000, 1'b1, 2, 0, 0, 32'h0};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 32'h00000000, 1'b0, 2, 0, 1, 32'h12341234};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h12347FFF, 1'b0, 3, 1, 0, 32'h0};
        vecs[16] = '{1'b1, 2'd1, 1'b0, 32'h23, 32'h0000FFFF, 32'h00000000, 1'b1, 2, 0, 0, 32'h0};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h12347FFF, 1'b0, 3, 1, 0, 32'h0};
        vecs[18] = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'h00001234, 1'b0, 3, 1, 0, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_valid3 = 1'b0; req_addr3 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_bus_addr", bus1.addr, 32'h0);
        chk("rst_bus_size", 32'(bus1.size), 32'd0);
        chk("rst_bus_wdata", bus1.wdata, 32'h0);
        chk("rst_bus_rdwr", 32'({bus1.rd, bus1.wr, bus3.rd, bus3.wr}), 32'd0);
        chk("rst_req_ready3", 32'(req_ready3), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // reset while in ISSUE: rd must drop immediately, no response afterwards
        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        chk("issue_rd_before_reset", 32'(bus1.rd), 32'd1);
        rst_n = 1'b0; #1;
        chk("issue_rd_in_reset", 32'(bus1.rd), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("issue_reset_ready", 32'(req_ready), 32'd1);
        got = 1'b0;
        repeat (5) begin @(negedge clk); if (rsp_valid) got = 1'b1; end
        chk("issue_reset_no_rsp", 32'(got), 32'd0);

        // reset during WAIT on the READ_LATENCY=3 instance
        @(posedge clk); #1 req_addr3 = 32'h40; req_valid3 = 1'b1;
        @(posedge clk); #1 req_valid3 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("wait_reset_ready3", 32'(req_ready3), 32'd1);
        got = rsp_valid3;
        repeat (8) begin @(negedge clk); if (rsp_valid3) got = 1'b1; end
        chk("wait_reset_no_rsp3", 32'(got), 32'd0);
        cnt3 = 0;
        @(posedge clk); #1 req_addr3 = 32'h44; req_valid3 = 1'b1;
        @(posedge clk); #1 req_valid3 = 1'b0;
        n = 0; got = 1'b0;
        while (n < 12 && !got) begin @(negedge clk); n++; if (rsp_valid3) got = 1'b1; end
        cnt3 = got ? n : -1;
        chk("lat3_latency", 32'(cnt3), 32'd5);
        chk("lat3_rdata", rsp_rdata3, 32'h12345678);
        chk("lat3_error", 32'(rsp_error3), 32'd0);

        // back-to-back: hold req_valid high across several requests
        @(negedge clk);
        hs_q.delete(); rsp_q.delete();
        n = rd1_cnt;
        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_hs_count_ge2", 32'(hs_q.size() >= 2), 32'd1);
        chk("b2b_rsp_count", 32'(rsp_q.size()), 32'(hs_q.size()));
        chk("b2b_rd_count", 32'(rd1_cnt - n), 32'(hs_q.size()));
        if (hs_q.size() >= 2 && rsp_q.size() >= 1) begin
            chk("b2b_first_latency", 32'(rsp_q[0] - hs_q[0]), 32'd3);
            chk("b2b_accept_after_resp", 32'(hs_q[1] - rsp_q[0]), 32'd1);
        end
        chk("b2b_rsp_data", rsp_rdata, 32'hA5ADBEEF);

        chk("no_overlap_pulses", 32'(ovl), 32'd0);
        chk("no_bus_in_reset", 32'(rstbus), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
